cam_cmp_lutram_multi: RTL
=========================

Name: cam_cmp_lutram_multi

Overview:
- Multi-entry, parametrised successor of the single-entry LUTRAM compare CAM.
- Each entry holds one KEY_W-bit key. Lookup is combinational: the compare key indexes one 32xENTRIES LUTRAM column-set per 5-bit key slice, and the slice outputs are ANDed per entry.
- Updates go through a handshaked request port and an internal FSM. The FSM clears the entry's old key bits before setting the new ones, and runs a full-array flush after reset or on request.
- Used by TLB and BTB tag match, where ENTRIES-way fully associative lookup has to finish in one cycle.

Parameters:
- KEY_W, 20, key width in bits. SLICES = ceil(KEY_W/5); the last slice is zero-padded in its upper bits.
- ENTRIES, 8, number of CAM entries, 2..32.
- IDX_W, $clog2(ENTRIES), entry index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  update request valid
- req_ready_o  out  1  FSM idle; request accepted when valid&ready
- req_op_i  in  2  0=WRITE, 1=INVALIDATE, 2=FLUSH, 3=reserved (treated as NOP, accepted)
- req_idx_i  in  IDX_W  target entry (WRITE/INVALIDATE)
- req_key_i  in  KEY_W  new key (WRITE)
- cmp_key_i  in  KEY_W  lookup key
- hit_o  out  ENTRIES  per-entry hit vector
- hit_any_o  out  1  OR of hit_o
- hit_idx_o  out  IDX_W  lowest set index of hit_o, 0 if none
- multi_hit_o  out  1  more than one bit of hit_o set
- valid_o  out  ENTRIES  entry valid flags
- rd_idx_i  in  IDX_W  key readback select
- rd_key_o  out  KEY_W  stored key of entry rd_idx_i (combinational)

Behaviour:
- Storage:
  - SLICES LUTRAM arrays, each 32 words x ENTRIES bits, 1 write port, 1 async read port addressed by the cmp_key_i slice.
  - key_q[ENTRIES] and valid_q[ENTRIES] are flops.
- Lookup: hit_o[e] = valid_q[e] & AND over s of ram[s][cmp_key_i slice s][e]. Zero-cycle latency.
- Reset (async): valid_q=0, key_q=0, state=FLUSH, flush counter=0, req_ready_o=0. All outputs derived from these, so hit_o=0 and rd_key_o=0.
- FSM states: IDLE, CLEAR, SET, FLUSH.
- IDLE: req_ready_o=1. On accept:
  - WRITE:
    - At the accept edge: valid_q[idx]<=0; old_key<=key_q[idx]; key_q[idx]<=req_key_i; latch idx.
    - Go to CLEAR.
  - INVALIDATE: valid_q[idx]<=0; old_key<=key_q[idx]; latch idx; go to CLEAR with set_pending=0.
  - FLUSH: valid_q<=all 0; counter<=0; go to FLUSH.
  - NOP: stay IDLE.
- CLEAR (1 cycle): in every slice s, write bit idx of word old_key slice s to 0; other bits keep their value (read-modify-write of the column via per-bit write enable). Next state is SET if WRITE, else IDLE.
- SET (1 cycle): in every slice s, write bit idx of word key_q[idx] slice s to 1. At the end edge, valid_q[idx]<=1. Go to IDLE.
- WRITE timing:
  - Accepted at edge T.
  - The entry misses from T+0 through the SET cycle.
  - The entry hits on the new key from cycle T+3.
  - req_ready_o is low for 2 cycles.
- INVALIDATE timing: the entry misses immediately after the accept edge. req_ready_o is low for 1 cycle.
- FLUSH: 32 cycles, counter 0..31. Each cycle writes the all-zero word at address=counter in every slice. Go to IDLE after counter=31. Lookups during FLUSH return all-miss.
- Lookups on other entries are unaffected by an in-flight CLEAR/SET.
- A WRITE of the key already held by another valid entry is allowed. Both entries then hit and multi_hit_o=1; duplicate detection is not the block's job.
- A WRITE of an entry with its own current key is correct: CLEAR then SET leaves the bit at 1.
- Reset mid-update: the FSM restarts in FLUSH, and no partially written entry is ever reported valid.
- Requests presented while req_ready_o=0 are ignored; the requester holds them.

Test Plan:
- Reset, hold req_valid_i=0 -> req_ready_o rises exactly 32 cycles after rst_n deasserts; hit_o=0 for every cmp_key.
- WRITE idx=3 key=0x12345 at T -> req_ready_o low at T+1,T+2; cmp_key=0x12345 gives hit_o=0x08, hit_idx_o=3 from T+3, miss before.
- Entry 3 holds 0x12345; WRITE idx=3 key=0x0ABCD -> cmp 0x12345 misses and cmp 0x0ABCD hits entry 3 from T+3; key 0x1234D (mixed slices) misses.
- WRITE entries 1 and 5 with 0x00001 -> hit_o=0x22, hit_idx_o=1, multi_hit_o=1; INVALIDATE idx=1 -> hit_o=0x20 on the next cycle, multi_hit_o=0.
- KEY_W=12 (partial slice): WRITE key 0xFFF -> hits; key 0x7FF misses; rd_key_o=0xFFF for rd_idx_i=idx.
- Fill all entries, issue FLUSH, then assert rst_n=0 during cycle 10 of the flush -> valid_o=0 immediately; a fresh 32-cycle flush runs; all lookups miss afterwards.

Source files
------------

// File: rtl/cam_cmp_lutram_multi.sv
// Multi-entry LUTRAM compare CAM: one 32xENTRIES column-set per 5-bit key slice,
// single-cycle lookup, handshaked WRITE/INVALIDATE/FLUSH via a small update FSM.
module cam_cmp_lutram_multi #(
   parameter int unsigned  KEY_W   = 20,
   parameter int unsigned  ENTRIES = 8,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [1:0]         req_op_i,
   input  logic [IDX_W-1:0]   req_idx_i,
   input  logic [KEY_W-1:0]   req_key_i,
   input  logic [KEY_W-1:0]   cmp_key_i,
   output logic [ENTRIES-1:0] hit_o,
   output logic               hit_any_o,
   output logic [IDX_W-1:0]   hit_idx_o,
   output logic               multi_hit_o,
   output logic [ENTRIES-1:0] valid_o,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic [KEY_W-1:0]   rd_key_o
);

   localparam int unsigned SLICES = (KEY_W + 4) / 5;
   localparam int unsigned PAD_W  = SLICES * 5;
   localparam int unsigned DEPTH  = 32;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_INV   = 2'd1;
   localparam logic [1:0] OP_FLUSH = 2'd2;
   localparam logic [4:0] CNT_LAST = 5'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SET, S_FLUSH} state_e;

   state_e                         state_q;
   logic [4:0]                     cnt_q;
   logic                           ready_q;
   logic                           set_pend_q;
   logic [IDX_W-1:0]               idx_q;
   logic [KEY_W-1:0]               old_key_q;
   logic [ENTRIES-1:0]             valid_q;
   logic [ENTRIES-1:0][KEY_W-1:0]  key_q;

   logic                           flush_we_c;
   logic                           bit_we_c;
   logic                           bit_val_c;
   logic [PAD_W-1:0]               waddr_pad_c;
   logic [PAD_W-1:0]               cmp_pad_c;
   logic [ENTRIES-1:0]             col_c [SLICES];
   logic [ENTRIES-1:0]             hit_c;
   logic [IDX_W-1:0]               hit_idx_c;

   // Update FSM; valid drops at accept so a half-updated entry never reports a hit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FLUSH;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         set_pend_q <= 1'b0;
         idx_q      <= '0;
         old_key_q  <= '0;
         valid_q    <= '0;
         key_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i && ready_q) begin
                  case (req_op_i)
                     OP_WRITE: begin
                        valid_q[req_idx_i] <= 1'b0;
                        old_key_q          <= key_q[req_idx_i];
                        key_q[req_idx_i]   <= req_key_i;
                        idx_q              <= req_idx_i;
                        set_pend_q         <= 1'b1;
                        ready_q            <= 1'b0;
                        state_q            <= S_CLEAR;
                     end
                     OP_INV: begin
                        valid_q[req_idx_i] <= 1'b0;
                        old_key_q          <= key_q[req_idx_i];
                        idx_q              <= req_idx_i;
                        set_pend_q         <= 1'b0;
                        ready_q            <= 1'b0;
                        state_q            <= S_CLEAR;
                     end
                     OP_FLUSH: begin
                        valid_q <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_FLUSH;
                     end
                     default: ;
                  endcase
               end
            end
            S_CLEAR: begin
               if (set_pend_q) begin
                  state_q <= S_SET;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            S_SET: begin
               valid_q[idx_q] <= 1'b1;
               ready_q        <= 1'b1;
               state_q        <= S_IDLE;
            end
            S_FLUSH: begin
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == CNT_LAST) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_FLUSH;
         endcase
      end
   end

   // RAM write controls: CLEAR zeroes the old key's bit, SET raises the new key's bit
   always_comb begin
      flush_we_c  = (state_q == S_FLUSH);
      bit_we_c    = (state_q == S_CLEAR) || (state_q == S_SET);
      bit_val_c   = (state_q == S_SET);
      waddr_pad_c = (state_q == S_SET) ? PAD_W'(key_q[idx_q]) : PAD_W'(old_key_q);
   end

   assign cmp_pad_c = PAD_W'(cmp_key_i);

   genvar s;
   for (s = 0; s < SLICES; s++) begin : g_slice
      logic [ENTRIES-1:0] mem [DEPTH];
      logic [4:0]         waddr;
      logic [4:0]         raddr;

      assign waddr = waddr_pad_c[s*5 +: 5];
      assign raddr = cmp_pad_c[s*5 +: 5];

      always_ff @(posedge clk) begin
         if (flush_we_c) begin
            mem[cnt_q] <= '0;
         end else if (bit_we_c) begin
            mem[waddr][idx_q] <= bit_val_c;
         end
      end

      assign col_c[s] = mem[raddr];
   end

   always_comb begin
      hit_c = valid_q;
      for (int unsigned i = 0; i < SLICES; i++) begin
         hit_c = hit_c & col_c[i];
      end
   end

   // Lowest set index wins
   always_comb begin
      hit_idx_c = '0;
      for (int e = int'(ENTRIES) - 1; e >= 0; e--) begin
         if (hit_c[e]) hit_idx_c = IDX_W'(e);
      end
   end

   assign hit_o       = hit_c;
   assign hit_any_o   = |hit_c;
   assign hit_idx_o   = hit_idx_c;
   assign multi_hit_o = |(hit_c & (hit_c - ENTRIES'(1)));
   assign valid_o     = valid_q;
   assign req_ready_o = ready_q;
   assign rd_key_o    = key_q[rd_idx_i];

endmodule
